rv32im_bus_arbiter: RTL
=======================

RV32IM_BUS_ARBITER -- requirements
Module: rv32im_bus_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, slave-stall limit in cycles, range 1..65535.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_req_i, m1_req_i  input  1  bus request (m0 = instruction prefetch, m1 = load/store).
REQ-006 SHALL have ports m0_grant_o, m1_grant_o  output  1  bus ownership, registered.
REQ-007 SHALL have ports mN_adr_i  input  XLEN-2  word address; mN_dat_i  input  XLEN  write data; mN_we_i  input  1; mN_sel_i  input  4; mN_stb_i  input  1 (N=0,1).
REQ-008 SHALL have ports mN_dat_o  output  XLEN  read data; mN_ack_o  output  1; mN_err_o  output  1 (N=0,1).
REQ-009 SHALL have slave ports s_adr_o  output  XLEN-2; s_dat_o  output  XLEN; s_we_o  output  1; s_sel_o  output  4; s_stb_o  output  1; s_cyc_o  output  1.
REQ-010 SHALL have slave ports s_dat_i  input  XLEN; s_ack_i  input  1; s_err_i  input  1.
REQ-011 SHALL have port bus_timeout_o  output  1  one-cycle pulse on slave timeout.

Function
REQ-012 SHALL implement states IDLE, OWN0, OWN1; mN_grant_o high exactly in OWNN.
REQ-013 IDLE: single request -> OWN of that master at next edge (grant one cycle after req sampled).
REQ-014 IDLE, both requests -> master not served last wins (round-robin); last-served register updates on each entry to OWNx.
REQ-015 OWNx: stay while mx_req_i high; on mx_req_i low, go to OWN of other master if its req high (zero-bubble handoff), else IDLE.
REQ-016 Ownership SHALL NOT change while s_stb_o high and no ack/err received; a req drop during an outstanding access defers release until ack, err or timeout.
REQ-017 In OWNx, s_adr_o/s_dat_o/s_we_o/s_sel_o SHALL mux combinationally from master x; s_stb_o = mx_stb_i; s_cyc_o = s_stb_o.
REQ-018 In IDLE, s_stb_o, s_cyc_o, s_we_o SHALL be 0; s_sel_o, s_adr_o, s_dat_o 0.
REQ-019 mx_ack_o = s_ack_i & OWNx; mx_err_o = (s_err_i | timeout pulse) & OWNx; non-owner ack/err always 0.
REQ-020 mN_dat_o SHALL both carry s_dat_i (qualified only by ack).
REQ-021 Acks arriving while s_stb_o low SHALL be discarded (not forwarded).

Reset
REQ-022 reset_i low SHALL immediately force state IDLE, both grants 0, bus_timeout_o 0, timeout counter 0, last-served = m1 (m0 wins first tie).
REQ-023 Reset asserted mid-access SHALL drop s_stb_o/s_cyc_o asynchronously; no ack/err forwarded afterwards.
REQ-024 First arbitration SHALL occur on the first rising edge after reset_i deasserts.

Configuration
REQ-025 Macro RV32IM_BUS_ARBITER_TIMEOUT_EN SHALL compile in the stall watchdog.
REQ-026 Defined: 16-bit counter increments each cycle s_stb_o high without s_ack_i/s_err_i, clears on ack/err, stb low or ownership change; on reaching TIMEOUT_CYCLES assert mx_err_o and bus_timeout_o one cycle, clear counter, treat access complete.
REQ-027 Undefined: no counter, bus_timeout_o tied 0, accesses wait indefinitely; TIMEOUT_CYCLES ignored.

Verification
REQ-028 Reset release, m0_req_i=1 at cycle 0 -> m0_grant_o=1 at cycle 1, s_adr_o = m0_adr_i, m1_grant_o=0.
REQ-029 Both req held from IDLE after reset -> grant order m0, m1, m0 as each owner drops req for one cycle; handoff with no IDLE cycle.
REQ-030 m1 owns, s_stb_o=1, m1 drops req before s_ack_i (3-cycle stall) -> m1_grant_o held until ack cycle; m1_ack_o=1, m0_ack_o=0; m0 granted next edge.
REQ-031 TIMEOUT_EN defined, TIMEOUT_CYCLES=4, slave never acks -> m0_err_o and bus_timeout_o high for exactly one cycle 4 cycles after stb; undefined -> stb stays high, no err.
REQ-032 reset_i pulsed low mid-access with s_ack_i arriving in same cycle -> grants and s_stb_o 0 without clock edge; no mN_ack_o pulse.

Source files
------------

// File: rtl/rv32im_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the slave.
// Ports: m0/m1 request/grant and access lines, s_* slave lines, bus_timeout_o.
interface rv32im_bus_arbiter_if #(
  parameter int XLEN = 32
);
  logic            m0_req_i;
  logic            m1_req_i;
  logic            m0_grant_o;
  logic            m1_grant_o;
  logic [XLEN-3:0] m0_adr_i;
  logic [XLEN-3:0] m1_adr_i;
  logic [XLEN-1:0] m0_dat_i;
  logic [XLEN-1:0] m1_dat_i;
  logic            m0_we_i;
  logic            m1_we_i;
  logic [3:0]      m0_sel_i;
  logic [3:0]      m1_sel_i;
  logic            m0_stb_i;
  logic            m1_stb_i;
  logic [XLEN-1:0] m0_dat_o;
  logic [XLEN-1:0] m1_dat_o;
  logic            m0_ack_o;
  logic            m1_ack_o;
  logic            m0_err_o;
  logic            m1_err_o;
  logic [XLEN-3:0] s_adr_o;
  logic [XLEN-1:0] s_dat_o;
  logic            s_we_o;
  logic [3:0]      s_sel_o;
  logic            s_stb_o;
  logic            s_cyc_o;
  logic [XLEN-1:0] s_dat_i;
  logic            s_ack_i;
  logic            s_err_i;
  logic            bus_timeout_o;

  modport arbiter (
    input  m0_req_i, m1_req_i,
    input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i,
    input  m0_we_i, m1_we_i, m0_sel_i, m1_sel_i,
    input  m0_stb_i, m1_stb_i,
    output m0_grant_o, m1_grant_o,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o,
    output m0_err_o, m1_err_o,
    output s_adr_o, s_dat_o, s_we_o, s_sel_o,
    output s_stb_o, s_cyc_o,
    input  s_dat_i, s_ack_i, s_err_i,
    output bus_timeout_o
  );

  modport master (
    output m0_req_i, m1_req_i,
    output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i,
    output m0_we_i, m1_we_i, m0_sel_i, m1_sel_i,
    output m0_stb_i, m1_stb_i,
    input  m0_grant_o, m1_grant_o,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o,
    input  m0_err_o, m1_err_o
  );

  modport slave (
    input  s_adr_o, s_dat_o, s_we_o, s_sel_o,
    input  s_stb_o, s_cyc_o,
    output s_dat_i, s_ack_i, s_err_i,
    input  bus_timeout_o
  );
endinterface

// File: rtl/rv32im_bus_arbiter.sv
// Two-master round-robin arbiter (m0 fetch, m1 load/store) onto one slave.
// Ports: clk_i, reset_i (async, active-low), bus (arbiter modport).
// Macro RV32IM_BUS_ARBITER_TIMEOUT_EN adds the slave-stall watchdog.
module rv32im_bus_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk_i,
  input logic                  reset_i,
  rv32im_bus_arbiter_if.arbiter bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e state_q;
  state_e state_n;
  logic   last_q;
  logic   g0_q;
  logic   g1_q;
  logic   own0;
  logic   own1;
  logic   tmo;
  logic   busy;

  logic [XLEN-3:0] adr;
  logic [XLEN-1:0] dat;
  logic            we;
  logic [3:0]      sel;
  logic            stb;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  always_comb begin
    adr = '0;
    dat = '0;
    we  = 1'b0;
    sel = '0;
    stb = 1'b0;
    unique case (1'b1)
      own0: begin
        adr = bus.m0_adr_i;
        dat = bus.m0_dat_i;
        we  = bus.m0_we_i;
        sel = bus.m0_sel_i;
        stb = bus.m0_stb_i;
      end
      own1: begin
        adr = bus.m1_adr_i;
        dat = bus.m1_dat_i;
        we  = bus.m1_we_i;
        sel = bus.m1_sel_i;
        stb = bus.m1_stb_i;
      end
      default: ;
    endcase
  end

  // An access is open until the slave answers or the watchdog fires.
  assign busy = stb & ~(bus.s_ack_i | bus.s_err_i | tmo);

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req_i && bus.m1_req_i)
          state_n = last_q ? OWN0 : OWN1;
        else if (bus.m0_req_i)
          state_n = OWN0;
        else if (bus.m1_req_i)
          state_n = OWN1;
      end
      OWN0: begin
        if (!bus.m0_req_i && !busy)
          state_n = bus.m1_req_i ? OWN1 : IDLE;
      end
      OWN1: begin
        if (!bus.m1_req_i && !busy)
          state_n = bus.m0_req_i ? OWN0 : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      g0_q    <= 1'b0;
      g1_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      g0_q    <= (state_n == OWN0);
      g1_q    <= (state_n == OWN1);
      if (state_n == OWN0 && state_q != OWN0)
        last_q <= 1'b0;
      else if (state_n == OWN1 && state_q != OWN1)
        last_q <= 1'b1;
    end
  end

`ifdef RV32IM_BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] Lim = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q;
  logic        tmo_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      if (!busy || state_n != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q + 16'd1 == Lim) begin
        cnt_q <= '0;
        tmo_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign tmo = tmo_q;
`else
  // Watchdog compiled out; the legal range is >= 1 so this folds to 0.
  assign tmo = (TIMEOUT_CYCLES < 1);
`endif

  assign bus.m0_grant_o  = g0_q;
  assign bus.m1_grant_o  = g1_q;
  assign bus.s_adr_o     = adr;
  assign bus.s_dat_o     = dat;
  assign bus.s_we_o      = we;
  assign bus.s_sel_o     = sel;
  assign bus.s_stb_o     = stb;
  assign bus.s_cyc_o     = stb;
  assign bus.m0_dat_o    = bus.s_dat_i;
  assign bus.m1_dat_o    = bus.s_dat_i;
  // Acks with no strobe out are stray and dropped.
  assign bus.m0_ack_o    = bus.s_ack_i & stb & own0;
  assign bus.m1_ack_o    = bus.s_ack_i & stb & own1;
  assign bus.m0_err_o    = (bus.s_err_i | tmo) & own0;
  assign bus.m1_err_o    = (bus.s_err_i | tmo) & own1;
  assign bus.bus_timeout_o = tmo;

endmodule
